// File: rtl/tinyriscv_pkg.sv
// +----------------------------------------------------------------------+
// | Module   : tinyriscv_pkg                                             |
// | Brief    : Shared types and constants for the RIB shared-bus fabric  |
// | Revision : 1.0                                                       |
// +----------------------------------------------------------------------+
`default_nettype none

package tinyriscv_pkg;

  // Bus FSM states: arbitration, slave access, decode-miss response
  typedef enum logic [1:0] {
    RIB_IDLE   = 2'd0,
    RIB_ACTIVE = 2'd1,
    RIB_ERR    = 2'd2
  } rib_state_e;

  // Read data returned on a decode miss or a slave timeout
  localparam logic [31:0] RIB_ERR_DATA = 32'hDEAD_BEEF;

  // Slave-select field width; a single slave still needs one select bit
  function automatic int rib_sel_w(input int ns);
    return (ns > 1) ? $clog2(ns) : 1;
  endfunction

endpackage

`default_nettype wire

// File: rtl/rib_shared_bus_arbiter.sv
// +----------------------------------------------------------------------+
// | Module   : rib_arbiter                                               |
// | Brief    : Master arbiter, one-hot grant plus binary index.          |
// |            RIB_RR_ARB_EN defined  : round-robin from pointer ptr     |
// |            RIB_RR_ARB_EN undefined: fixed priority, index 0 highest  |
// | Revision : 1.0                                                       |
// +----------------------------------------------------------------------+
`default_nettype none

module rib_arbiter
  import tinyriscv_pkg::*;
#(
  parameter int NM = 4,
  parameter int IW = (NM > 1) ? $clog2(NM) : 1
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic [NM-1:0] req_i,
  input  logic          adv_i,
  input  logic [IW-1:0] adv_idx_i,
  output logic [NM-1:0] gnt_o,
  output logic [IW-1:0] gnt_idx_o
);

`ifdef RIB_RR_ARB_EN
  logic [IW-1:0] ptr_q;
  logic [IW-1:0] ptr_d;

  // Pointer moves just past the master that completed; aborts leave it alone
  always_comb begin
    ptr_d = ptr_q;
    if (adv_i) begin
      ptr_d = (32'(adv_idx_i) == NM - 1) ? '0 : adv_idx_i + 1'b1;
    end
  end

  // Pointer register
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      ptr_q <= '0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

  // Search requesters starting at the pointer, wrapping modulo NM
  always_comb begin : b_rr
    int   idx;
    logic found;
    gnt_o     = '0;
    gnt_idx_o = '0;
    found     = 1'b0;
    idx       = 0;
    for (int o = 0; o < NM; o++) begin
      idx = (int'(ptr_q) + o) % NM;
      if (!found && req_i[idx]) begin
        found     = 1'b1;
        gnt_idx_o = IW'(idx);
      end
    end
    if (found) begin
      gnt_o[gnt_idx_o] = 1'b1;
    end
  end
`else
  // Fixed priority: scanning downward leaves the lowest requester selected
  always_comb begin
    gnt_o     = '0;
    gnt_idx_o = '0;
    for (int i = NM - 1; i >= 0; i--) begin
      if (req_i[i]) begin
        gnt_idx_o = IW'(i);
      end
    end
    if (|req_i) begin
      gnt_o[gnt_idx_o] = 1'b1;
    end
  end

  logic unused_rr;
  assign unused_rr = ^{clk_i, rst_ni, adv_i, adv_idx_i};
`endif

endmodule

`default_nettype wire

// File: rtl/rib_shared_bus.sv
// +----------------------------------------------------------------------+
// | Module   : rib_shared_bus                                            |
// | Brief    : NM-master / NS-slave shared RIB bus with one arbitrated   |
// |            path, decode-miss error response and slave timeout.       |
// |            RIB_RR_ARB_EN selects round-robin arbitration.            |
// | Revision : 1.0                                                       |
// +----------------------------------------------------------------------+
`default_nettype none

module rib_shared_bus
  import tinyriscv_pkg::*;
#(
  parameter int             NM       = 4,
  parameter int             NS       = 8,
  parameter int             AW       = 32,
  parameter int             DW       = 32,
  parameter int             CORE_M   = 2,
  parameter int             TIMEOUT  = 255,
  parameter logic [DW-1:0]  ERR_DATA = DW'(RIB_ERR_DATA)
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic [NM-1:0]    m_req_i,
  input  logic [NM-1:0]    m_we_i,
  input  logic [NM*AW-1:0] m_addr_i,
  input  logic [NM*DW-1:0] m_wdata_i,
  output logic [NM*DW-1:0] m_rdata_o,
  output logic [NM-1:0]    m_ready_o,
  output logic [NS-1:0]    s_req_o,
  output logic [NS-1:0]    s_we_o,
  output logic [NS*AW-1:0] s_addr_o,
  output logic [NS*DW-1:0] s_wdata_o,
  input  logic [NS*DW-1:0] s_rdata_i,
  input  logic [NS-1:0]    s_ready_i,
  output logic             hold_flag_o
);

  localparam int SEL_W = rib_sel_w(NS);
  localparam int IW    = (NM > 1) ? $clog2(NM) : 1;
  localparam int TW    = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  // Slaves see the full address with the select field zeroed
  localparam logic [AW-1:0] ADDR_MASK = {{SEL_W{1'b0}}, {(AW - SEL_W){1'b1}}};

  rib_state_e       state_q, state_d;
  logic [IW-1:0]    g_q, g_d;
  logic [SEL_W-1:0] sel_q, sel_d;
  logic             hold_q, hold_d;
  logic [TW-1:0]    cnt_q, cnt_d;

  logic [NM-1:0]    arb_gnt;
  logic [IW-1:0]    arb_idx;
  logic             adv;
  logic [SEL_W-1:0] new_sel;
  logic             slv_ready;
  logic             timeout_hit;

  rib_arbiter #(.NM(NM), .IW(IW)) u_arb (
    .clk_i     (clk_i),
    .rst_ni    (rst_ni),
    .req_i     (m_req_i),
    .adv_i     (adv),
    .adv_idx_i (g_q),
    .gnt_o     (arb_gnt),
    .gnt_idx_o (arb_idx)
  );

  assign new_sel     = m_addr_i[arb_idx*AW + AW - 1 -: SEL_W];
  assign slv_ready   = s_ready_i[sel_q];
  assign timeout_hit = (TIMEOUT != 0) && (cnt_q == TW'(TIMEOUT));

  // State register: grant, decoded slave, hold flag and wait counter
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q <= RIB_IDLE;
      g_q     <= '0;
      sel_q   <= '0;
      hold_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      g_q     <= g_d;
      sel_q   <= sel_d;
      hold_q  <= hold_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next state: arbitrate and decode in IDLE, then complete, abort or time out
  always_comb begin
    state_d = state_q;
    g_d     = g_q;
    sel_d   = sel_q;
    hold_d  = hold_q;
    cnt_d   = cnt_q;
    adv     = 1'b0;
    case (state_q)
      RIB_IDLE: begin
        if (|arb_gnt) begin
          g_d     = arb_idx;
          sel_d   = new_sel;
          hold_d  = (32'(arb_idx) >= CORE_M);
          cnt_d   = '0;
          state_d = (32'(new_sel) < NS) ? RIB_ACTIVE : RIB_ERR;
        end
      end
      RIB_ACTIVE: begin
        if (slv_ready) begin
          adv     = 1'b1;
          hold_d  = 1'b0;
          state_d = RIB_IDLE;
        end else if (!m_req_i[g_q]) begin
          hold_d  = 1'b0;
          state_d = RIB_IDLE;
        end else if (timeout_hit) begin
          adv     = 1'b1;
          hold_d  = 1'b0;
          state_d = RIB_IDLE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      RIB_ERR: begin
        adv     = 1'b1;
        hold_d  = 1'b0;
        state_d = RIB_IDLE;
      end
      default: begin
        hold_d  = 1'b0;
        state_d = RIB_IDLE;
      end
    endcase
  end

  // Outputs: route the granted master to its slave; everything 0 in reset
  always_comb begin
    m_rdata_o   = '0;
    m_ready_o   = '0;
    s_req_o     = '0;
    s_we_o      = '0;
    s_addr_o    = '0;
    s_wdata_o   = '0;
    hold_flag_o = 1'b0;
    if (rst_ni) begin
      hold_flag_o = hold_q;
      case (state_q)
        RIB_ACTIVE: begin
          s_req_o[sel_q]              = 1'b1;
          s_we_o[sel_q]               = m_we_i[g_q];
          s_addr_o[sel_q*AW +: AW]    = m_addr_i[g_q*AW +: AW] & ADDR_MASK;
          s_wdata_o[sel_q*DW +: DW]   = m_wdata_i[g_q*DW +: DW];
          if (slv_ready) begin
            m_ready_o[g_q]            = 1'b1;
            m_rdata_o[g_q*DW +: DW]   = s_rdata_i[sel_q*DW +: DW];
          end else if (timeout_hit && m_req_i[g_q]) begin
            m_ready_o[g_q]            = 1'b1;
            m_rdata_o[g_q*DW +: DW]   = ERR_DATA;
          end
        end
        RIB_ERR: begin
          m_ready_o[g_q]              = 1'b1;
          m_rdata_o[g_q*DW +: DW]     = ERR_DATA;
        end
        default: ;
      endcase
    end
  end

endmodule

`default_nettype wire
